// File: rtl/usb2_ep_router_if.sv
// Packet-layer side of the USB 2.0 endpoint router.
// The packet layer takes the master modport and the router takes the slave modport.
interface usb2_ep_router_if #(
  parameter int AW = 11,
  parameter int LW = 11
);
  // Transaction control
  logic          txn_start;
  logic          txn_end;
  logic [3:0]    sel_endp;

  // OUT-data write path into the locked endpoint
  logic [AW-1:0] buf_in_addr;
  logic [7:0]    buf_in_data;
  logic          buf_in_wren;
  logic          buf_in_commit;
  logic [LW-1:0] buf_in_commit_len;
  logic          buf_in_ready;
  logic          buf_in_commit_ack;

  // IN-data read path and re-arm handshake
  logic [AW-1:0] buf_out_addr;
  logic [7:0]    buf_out_q;
  logic [LW-1:0] buf_out_len;
  logic          buf_out_hasdata;
  logic          buf_out_arm;
  logic          buf_out_arm_ack;
  logic          arm_timeout;

  // Data toggle, mode and halt status of the locked endpoint
  logic          data_toggle_act;
  logic          setup_rcvd;
  logic [1:0]    data_toggle;
  logic [1:0]    endp_mode;
  logic          endp_halted;
  logic          endp_invalid;
  logic          halt_set;
  logic          halt_clr;
  logic [3:0]    halt_idx;

  modport master (
    output txn_start, txn_end, sel_endp,
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    input  buf_in_ready, buf_in_commit_ack,
    output buf_out_addr, buf_out_arm,
    input  buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, arm_timeout,
    output data_toggle_act, setup_rcvd, halt_set, halt_clr, halt_idx,
    input  data_toggle, endp_mode, endp_halted, endp_invalid
  );

  modport slave (
    input  txn_start, txn_end, sel_endp,
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len,
    output buf_in_ready, buf_in_commit_ack,
    input  buf_out_addr, buf_out_arm,
    output buf_out_q, buf_out_len, buf_out_hasdata, buf_out_arm_ack, arm_timeout,
    input  data_toggle_act, setup_rcvd, halt_set, halt_clr, halt_idx,
    output data_toggle, endp_mode, endp_halted, endp_invalid
  );
endinterface

// File: rtl/usb2_ep_router.sv
// Transaction-locked router between the USB 2.0 packet layer and NUM_EP
// endpoint buffers. A token locks one endpoint for the whole transaction; data
// paths of that endpoint are forwarded combinationally, all others read 0.
// Tracks per-endpoint data toggle and halt state and runs the buffer re-arm
// handshake with a timeout.
// Optional build macro USB2_EP_ROUTER_STATS_EN adds per-endpoint ack counters
// readable through stat_sel / stat_count.
module usb2_ep_router #(
  parameter int          NUM_EP   = 5,
  parameter logic [31:0] EP_MODES = 32'h0000_0260,
  parameter int          AW       = 11,
  parameter int          LW       = 11,
  parameter int          ARM_TMO  = 255
) (
  input  logic                 phy_clk,
  input  logic                 reset,
  usb2_ep_router_if.slave      pkt,

  output logic [NUM_EP*AW-1:0] ep_buf_in_addr,
  output logic [NUM_EP*8-1:0]  ep_buf_in_data,
  output logic [NUM_EP-1:0]    ep_buf_in_wren,
  output logic [NUM_EP-1:0]    ep_buf_in_commit,
  output logic [NUM_EP*LW-1:0] ep_buf_in_commit_len,
  input  logic [NUM_EP-1:0]    ep_buf_in_ready,
  input  logic [NUM_EP-1:0]    ep_buf_in_commit_ack,

  output logic [NUM_EP*AW-1:0] ep_buf_out_addr,
  output logic [NUM_EP-1:0]    ep_buf_out_arm,
  input  logic [NUM_EP*8-1:0]  ep_buf_out_q,
  input  logic [NUM_EP*LW-1:0] ep_buf_out_len,
  input  logic [NUM_EP-1:0]    ep_buf_out_hasdata,
  input  logic [NUM_EP-1:0]    ep_buf_out_arm_ack
`ifdef USB2_EP_ROUTER_STATS_EN
  ,
  input  logic [3:0]           stat_sel,
  output logic [15:0]          stat_count
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOCKED   = 2'd1,
    ARM_WAIT = 2'd2
  } state_e;

  localparam int            TW      = (ARM_TMO < 1) ? 1 : $clog2(ARM_TMO + 1);
  localparam logic [TW-1:0] TMO_VAL = TW'(ARM_TMO);
  localparam logic [1:0]    MODE_ISOCH = 2'd1;

  // Endpoint 0 is always control regardless of the mode table.
  function automatic logic [1:0] mode_of(input int n);
    if (n == 0) return 2'd0;
    return EP_MODES[2*n +: 2];
  endfunction

  state_e                 state_q;
  logic [3:0]             cur_ep_q;
  logic [TW-1:0]          timer_q;
  logic                   end_pend_q;
  logic [2*NUM_EP-1:0]    toggle_q, toggle_d;
  logic [NUM_EP-1:0]      halt_q, halt_d;

  logic route_en;
  logic arm_wait;
  logic tmo_hit;
  logic ep_hit;
  logic sel_arm_ack;
  logic ack_seen;
  logic tmo_seen;

  assign route_en = (state_q != IDLE);
  // Gated by reset so that a reset during ARM_WAIT never emits an ack/timeout.
  assign arm_wait = (state_q == ARM_WAIT) && !reset;
  assign tmo_hit  = (timer_q == TMO_VAL);

  // Route the locked endpoint to the packet layer; everything else reads 0.
  always_comb begin
    ep_buf_in_addr         = '0;
    ep_buf_in_data         = '0;
    ep_buf_in_wren         = '0;
    ep_buf_in_commit       = '0;
    ep_buf_in_commit_len   = '0;
    ep_buf_out_addr        = '0;
    ep_buf_out_arm         = '0;
    pkt.buf_in_ready       = 1'b0;
    pkt.buf_in_commit_ack  = 1'b0;
    pkt.buf_out_q          = '0;
    pkt.buf_out_len        = '0;
    pkt.buf_out_hasdata    = 1'b0;
    pkt.data_toggle        = '0;
    pkt.endp_mode          = '0;
    pkt.endp_halted        = 1'b0;
    ep_hit                 = 1'b0;
    sel_arm_ack            = 1'b0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (cur_ep_q == 4'(n)) begin
        ep_hit          = 1'b1;
        sel_arm_ack     = ep_buf_out_arm_ack[n];
        pkt.data_toggle = toggle_q[2*n +: 2];
        pkt.endp_mode   = mode_of(n);
        pkt.endp_halted = halt_q[n];
        if (route_en) begin
          ep_buf_in_addr[n*AW +: AW]       = pkt.buf_in_addr;
          ep_buf_in_data[n*8 +: 8]         = pkt.buf_in_data;
          ep_buf_in_wren[n]                = pkt.buf_in_wren;
          ep_buf_in_commit[n]              = pkt.buf_in_commit;
          ep_buf_in_commit_len[n*LW +: LW] = pkt.buf_in_commit_len;
          ep_buf_out_addr[n*AW +: AW]      = pkt.buf_out_addr;
          // Arm is a level while waiting, dropped in the ack or timeout cycle.
          ep_buf_out_arm[n]                = arm_wait && !tmo_hit && !ep_buf_out_arm_ack[n];
          pkt.buf_in_ready                 = ep_buf_in_ready[n];
          pkt.buf_in_commit_ack            = ep_buf_in_commit_ack[n];
          pkt.buf_out_q                    = ep_buf_out_q[n*8 +: 8];
          pkt.buf_out_len                  = ep_buf_out_len[n*LW +: LW];
          pkt.buf_out_hasdata              = ep_buf_out_hasdata[n];
        end
      end
    end
  end

  assign pkt.endp_invalid = !ep_hit;
  // An ack wins over a timeout landing in the same cycle; an invalid endpoint
  // can never ack, so it times out on the first ARM_WAIT cycle.
  assign ack_seen            = arm_wait && sel_arm_ack;
  assign tmo_seen            = arm_wait && !ack_seen && (!ep_hit || tmo_hit);
  assign pkt.buf_out_arm_ack = ack_seen;
  assign pkt.arm_timeout     = tmo_seen;

  // Transaction FSM: endpoint lock, arm wait timer and deferred txn_end.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_ep_q   <= '0;
      timer_q    <= '0;
      end_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          end_pend_q <= 1'b0;
          timer_q    <= '0;
          if (pkt.txn_start) begin
            cur_ep_q <= pkt.sel_endp;
            state_q  <= LOCKED;
          end
        end
        LOCKED: begin
          timer_q    <= '0;
          end_pend_q <= 1'b0;
          if (pkt.txn_end) begin
            state_q <= IDLE;
          end else if (pkt.buf_out_arm) begin
            state_q <= ARM_WAIT;
          end
        end
        ARM_WAIT: begin
          if (ack_seen || tmo_seen) begin
            state_q    <= (end_pend_q || pkt.txn_end) ? IDLE : LOCKED;
            timer_q    <= '0;
            end_pend_q <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
            if (pkt.txn_end) end_pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next toggle/halt per endpoint; later assignments carry higher priority.
  always_comb begin
    toggle_d = toggle_q;
    halt_d   = halt_q;
    for (int n = 0; n < NUM_EP; n++) begin
      if (pkt.halt_set && pkt.halt_idx == 4'(n)) halt_d[n] = 1'b1;
      if (pkt.data_toggle_act && state_q == LOCKED && cur_ep_q == 4'(n) &&
          mode_of(n) != MODE_ISOCH) begin
        toggle_d[2*n +: 2] = toggle_q[2*n +: 2] ^ 2'b01;
      end
      // A SETUP restarts ep0: first data stage is DATA1 and any stall is lifted.
      if (n == 0 && pkt.setup_rcvd) begin
        toggle_d[2*n +: 2] = 2'b01;
        halt_d[n]          = 1'b0;
      end
      if (pkt.halt_clr && pkt.halt_idx == 4'(n)) begin
        halt_d[n]          = 1'b0;
        toggle_d[2*n +: 2] = 2'b00;
      end
    end
  end

  // Toggle and halt state registers.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      toggle_q <= '0;
      halt_q   <= '0;
    end else begin
      toggle_q <= toggle_d;
      halt_q   <= halt_d;
    end
  end

`ifdef USB2_EP_ROUTER_STATS_EN
  logic [NUM_EP-1:0] stat_inc;
  logic [15:0]       stat_cnt_q [NUM_EP];
  logic [15:0]       stat_count_q;

  // An endpoint counts an event when it is routed and acks an arm or a commit.
  always_comb begin
    stat_inc = '0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (route_en && cur_ep_q == 4'(n)) begin
        stat_inc[n] = ep_buf_in_commit_ack[n] || (arm_wait && ep_buf_out_arm_ack[n]);
      end
    end
  end

  // Saturating per-endpoint counters and the registered read port.
  always_ff @(posedge phy_clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_EP; n++) stat_cnt_q[n] <= '0;
      stat_count_q <= '0;
    end else begin
      stat_count_q <= '0;
      for (int n = 0; n < NUM_EP; n++) begin
        if (stat_inc[n] && stat_cnt_q[n] != 16'hFFFF) stat_cnt_q[n] <= stat_cnt_q[n] + 16'd1;
        if (stat_sel == 4'(n)) stat_count_q <= stat_cnt_q[n];
      end
    end
  end

  assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_usb2_ep_router.sv
// Directed bench for usb2_ep_router: NUM_EP=5, ep1 overridden to bulk, ARM_TMO=8.
module tb_usb2_ep_router;
  localparam int NE = 5;
  localparam int AW = 11;
  localparam int LW = 11;

  logic phy_clk;
  logic reset;

  usb2_ep_router_if #(.AW(AW), .LW(LW)) pkt ();

  logic [NE*AW-1:0] ep_buf_in_addr;
  logic [NE*8-1:0]  ep_buf_in_data;
  logic [NE-1:0]    ep_buf_in_wren;
  logic [NE-1:0]    ep_buf_in_commit;
  logic [NE*LW-1:0] ep_buf_in_commit_len;
  logic [NE-1:0]    ep_buf_in_ready;
  logic [NE-1:0]    ep_buf_in_commit_ack;
  logic [NE*AW-1:0] ep_buf_out_addr;
  logic [NE-1:0]    ep_buf_out_arm;
  logic [NE*8-1:0]  ep_buf_out_q;
  logic [NE*LW-1:0] ep_buf_out_len;
  logic [NE-1:0]    ep_buf_out_hasdata;
  logic [NE-1:0]    ep_buf_out_arm_ack;
`ifdef USB2_EP_ROUTER_STATS_EN
  logic [3:0]       stat_sel;
  logic [15:0]      stat_count;
`endif

  int n_checks;
  int n_fail;
  logic [NE*AW-1:0] exp_addr;
  int arm_hi;
  int tmo_cnt;

  usb2_ep_router #(
    .NUM_EP(NE), .EP_MODES(32'h0000_0268), .AW(AW), .LW(LW), .ARM_TMO(8)
  ) dut (
    .phy_clk(phy_clk),
    .reset(reset),
    .pkt(pkt),
    .ep_buf_in_addr(ep_buf_in_addr),
    .ep_buf_in_data(ep_buf_in_data),
    .ep_buf_in_wren(ep_buf_in_wren),
    .ep_buf_in_commit(ep_buf_in_commit),
    .ep_buf_in_commit_len(ep_buf_in_commit_len),
    .ep_buf_in_ready(ep_buf_in_ready),
    .ep_buf_in_commit_ack(ep_buf_in_commit_ack),
    .ep_buf_out_addr(ep_buf_out_addr),
    .ep_buf_out_arm(ep_buf_out_arm),
    .ep_buf_out_q(ep_buf_out_q),
    .ep_buf_out_len(ep_buf_out_len),
    .ep_buf_out_hasdata(ep_buf_out_hasdata),
    .ep_buf_out_arm_ack(ep_buf_out_arm_ack)
`ifdef USB2_EP_ROUTER_STATS_EN
    ,
    .stat_sel(stat_sel),
    .stat_count(stat_count)
`endif
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge phy_clk);
    #1;
  endtask

  task automatic lock(input logic [3:0] ep);
    pkt.sel_endp  = ep;
    pkt.txn_start = 1'b1;
    step();
    pkt.txn_start = 1'b0;
  endtask

  task automatic end_txn();
    pkt.txn_end = 1'b1;
    step();
    pkt.txn_end = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    pkt.txn_start = 1'b0; pkt.txn_end = 1'b0; pkt.sel_endp = 4'd0;
    pkt.buf_in_addr = 11'h005; pkt.buf_in_data = 8'h00; pkt.buf_in_wren = 1'b0;
    pkt.buf_in_commit = 1'b0; pkt.buf_in_commit_len = '0;
    pkt.buf_out_addr = 11'h010; pkt.buf_out_arm = 1'b0;
    pkt.data_toggle_act = 1'b0; pkt.setup_rcvd = 1'b0;
    pkt.halt_set = 1'b0; pkt.halt_clr = 1'b0; pkt.halt_idx = 4'd0;
`ifdef USB2_EP_ROUTER_STATS_EN
    stat_sel = 4'd0;
`endif
    ep_buf_in_ready      = 5'b01010;
    ep_buf_in_commit_ack = '0;
    ep_buf_out_q         = {8'h44, 8'hA5, 8'h22, 8'h11, 8'h0F};
    for (int n = 0; n < NE; n++) ep_buf_out_len[n*LW +: LW] = 11'(100 + n);
    ep_buf_out_hasdata   = 5'b01000;
    ep_buf_out_arm_ack   = '0;

    step(); step();
    // Reset state
    check("rst_out_addr", 64'(ep_buf_out_addr), 64'd0);
    check("rst_arm", 64'(ep_buf_out_arm), 64'd0);
    check("rst_q", 64'(pkt.buf_out_q), 64'd0);
    check("rst_toggle", 64'(pkt.data_toggle), 64'd0);
    check("rst_halted", 64'(pkt.endp_halted), 64'd0);
    check("rst_invalid", 64'(pkt.endp_invalid), 64'd0);
    check("rst_tmo", 64'(pkt.arm_timeout), 64'd0);
    reset = 1'b0;
    step();

    // Routing on ep3 (isoch)
    lock(4'd3);
    pkt.buf_in_wren = 1'b1; pkt.buf_in_data = 8'h3C;
    #1;
    exp_addr = '0;
    exp_addr[3*AW +: AW] = 11'h010;
    check("route_q", 64'(pkt.buf_out_q), 64'hA5);
    check("route_mode", 64'(pkt.endp_mode), 64'd1);
    check("route_out_addr", 64'(ep_buf_out_addr), 64'(exp_addr));
    check("route_len", 64'(pkt.buf_out_len), 64'd103);
    check("route_hasdata", 64'(pkt.buf_out_hasdata), 64'd1);
    check("route_ready", 64'(pkt.buf_in_ready), 64'd1);
    check("route_wren", 64'(ep_buf_in_wren), 64'b01000);
    check("route_data", 64'(ep_buf_in_data), 64'h3C << 24);
    pkt.buf_in_wren = 1'b0;
    pkt.data_toggle_act = 1'b1;
    step();
    pkt.data_toggle_act = 1'b0;
    #1;
    check("isoch_toggle", 64'(pkt.data_toggle), 64'd0);
    lock(4'd1);
    #1;
    check("start_ignored", 64'(pkt.endp_mode), 64'd1);
    end_txn();
    #1;
    check("idle_out_addr", 64'(ep_buf_out_addr), 64'd0);
    check("idle_q", 64'(pkt.buf_out_q), 64'd0);

    // Arm handshake on ep2, acked on the fifth ARM_WAIT cycle
    lock(4'd2);
    pkt.buf_out_arm = 1'b1;
    step();
    pkt.buf_out_arm = 1'b0;
    #1;
    check("arm_only_ep2", 64'(ep_buf_out_arm), 64'b00100);
    arm_hi = 0; tmo_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      arm_hi  += int'(ep_buf_out_arm[2]);
      tmo_cnt += int'(pkt.arm_timeout);
      step();
    end
    ep_buf_out_arm_ack[2] = 1'b1;
    #1;
    check("arm_drop_on_ack", 64'(ep_buf_out_arm), 64'd0);
    check("arm_ack_pulse", 64'(pkt.buf_out_arm_ack), 64'd1);
    step();
    ep_buf_out_arm_ack[2] = 1'b0;
    #1;
    check("arm_ack_once", 64'(pkt.buf_out_arm_ack), 64'd0);
    check("arm_high_cycles", 64'(arm_hi), 64'd4);
    check("arm_no_tmo", 64'(tmo_cnt), 64'd0);

    // Arm timeout at timer value 8
    pkt.buf_out_arm = 1'b1;
    step();
    pkt.buf_out_arm = 1'b0;
    tmo_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tmo_cnt += int'(pkt.arm_timeout);
      step();
    end
    check("tmo_not_early", 64'(tmo_cnt), 64'd0);
    check("tmo_pulse", 64'(pkt.arm_timeout), 64'd1);
    check("tmo_arm_low", 64'(ep_buf_out_arm), 64'd0);
    step();
    check("tmo_once", 64'(pkt.arm_timeout), 64'd0);
    check("tmo_back_locked", 64'(pkt.buf_out_q), 64'h22);

    // txn_end during ARM_WAIT takes effect after the ack
    pkt.buf_out_arm = 1'b1;
    step();
    pkt.buf_out_arm = 1'b0;
    step();
    pkt.txn_end = 1'b1;
    step();
    pkt.txn_end = 1'b0;
    check("defer_arm_held", 64'(ep_buf_out_arm), 64'b00100);
    ep_buf_out_arm_ack[2] = 1'b1;
    #1;
    check("defer_ack", 64'(pkt.buf_out_arm_ack), 64'd1);
    step();
    ep_buf_out_arm_ack[2] = 1'b0;
    #1;
    check("defer_idle_q", 64'(pkt.buf_out_q), 64'd0);
    check("defer_idle_addr", 64'(ep_buf_out_addr), 64'd0);

    // Toggle and halt on ep1 (bulk)
    lock(4'd1);
    pkt.data_toggle_act = 1'b1;
    step(); step(); step();
    pkt.data_toggle_act = 1'b0;
    #1;
    check("toggle_3act", 64'(pkt.data_toggle), 64'd1);
    pkt.halt_set = 1'b1; pkt.halt_idx = 4'd1;
    step();
    pkt.halt_set = 1'b0;
    #1;
    check("halt_set", 64'(pkt.endp_halted), 64'd1);
    pkt.data_toggle_act = 1'b1;
    step();
    pkt.data_toggle_act = 1'b0;
    #1;
    check("toggle_4act", 64'(pkt.data_toggle), 64'd0);
    pkt.halt_clr = 1'b1; pkt.data_toggle_act = 1'b1;
    step();
    pkt.halt_clr = 1'b0; pkt.data_toggle_act = 1'b0;
    #1;
    check("clr_beats_act", 64'(pkt.data_toggle), 64'd0);
    check("clr_unhalt", 64'(pkt.endp_halted), 64'd0);
    pkt.halt_set = 1'b1;
    step();
    pkt.halt_set = 1'b0;
    #1;
    check("halt_set2", 64'(pkt.endp_halted), 64'd1);
    pkt.halt_set = 1'b1; pkt.halt_clr = 1'b1;
    step();
    pkt.halt_set = 1'b0; pkt.halt_clr = 1'b0;
    #1;
    check("set_clr_clr_wins", 64'(pkt.endp_halted), 64'd0);
    end_txn();

    // Invalid endpoint 9
    lock(4'd9);
    #1;
    check("inv_flag", 64'(pkt.endp_invalid), 64'd1);
    check("inv_q", 64'(pkt.buf_out_q), 64'd0);
    check("inv_out_addr", 64'(ep_buf_out_addr), 64'd0);
    check("inv_mode", 64'(pkt.endp_mode), 64'd0);
    pkt.buf_out_arm = 1'b1;
    step();
    pkt.buf_out_arm = 1'b0;
    #1;
    check("inv_tmo_next", 64'(pkt.arm_timeout), 64'd1);
    check("inv_no_arm", 64'(ep_buf_out_arm), 64'd0);
    step();
    check("inv_tmo_once", 64'(pkt.arm_timeout), 64'd0);
    end_txn();

    // ep0 SETUP handling
    lock(4'd0);
    #1;
    check("ep0_toggle0", 64'(pkt.data_toggle), 64'd0);
    pkt.setup_rcvd = 1'b1;
    step();
    pkt.setup_rcvd = 1'b0;
    #1;
    check("setup_data1", 64'(pkt.data_toggle), 64'd1);
    pkt.setup_rcvd = 1'b1; pkt.data_toggle_act = 1'b1;
    step();
    pkt.setup_rcvd = 1'b0; pkt.data_toggle_act = 1'b0;
    #1;
    check("setup_beats_act", 64'(pkt.data_toggle), 64'd1);
    pkt.halt_set = 1'b1; pkt.halt_idx = 4'd0;
    step();
    pkt.halt_set = 1'b0;
    #1;
    check("ep0_halt", 64'(pkt.endp_halted), 64'd1);
    pkt.setup_rcvd = 1'b1;
    step();
    pkt.setup_rcvd = 1'b0;
    #1;
    check("ep0_halt_autoclr", 64'(pkt.endp_halted), 64'd0);
    end_txn();

    // Reset in the middle of ARM_WAIT on ep4
    lock(4'd4);
    pkt.data_toggle_act = 1'b1;
    step();
    pkt.data_toggle_act = 1'b0;
    #1;
    check("ep4_toggle1", 64'(pkt.data_toggle), 64'd1);
    pkt.buf_out_arm = 1'b1;
    step();
    pkt.buf_out_arm = 1'b0;
    #1;
    check("ep4_arm", 64'(ep_buf_out_arm), 64'b10000);
    reset = 1'b1;
    step();
    check("rstm_arm", 64'(ep_buf_out_arm), 64'd0);
    check("rstm_ack", 64'(pkt.buf_out_arm_ack), 64'd0);
    check("rstm_tmo", 64'(pkt.arm_timeout), 64'd0);
    check("rstm_idle_q", 64'(pkt.buf_out_q), 64'd0);
    check("rstm_ep0_toggle", 64'(pkt.data_toggle), 64'd0);
    reset = 1'b0;
    step();
    lock(4'd4);
    #1;
    check("rstm_ep4_toggle", 64'(pkt.data_toggle), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
